upcounter_ctl: RTL



---
 rtl/upcounter_ctl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/upcounter_ctl.sv
// Programmable up-counter with wrap/stop terminal compare; optional sticky ovf under UPCNT_OVF_EN.
// Latency: count/wrap/busy/done/ovf update one edge after inputs; tc is combinational on count.
// Backpressure: none; en=0 holds the count in RUN.
module upcounter_ctl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             busy,
`ifdef UPCNT_OVF_EN
  output logic             done,
  output logic             ovf
`else
  output logic             done
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_term;
  logic             all_ones;

  assign at_term  = (count_q == term);
  assign all_ones = &count_q;

`ifdef UPCNT_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
`ifdef UPCNT_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (clear) begin
      count_d = '0;
      state_d = ST_IDLE;
`ifdef UPCNT_OVF_EN
      ovf_d   = 1'b0;
`endif
    end else if (load) begin
      // Loading out of HALT re-arms the counter via IDLE.
      count_d = load_val;
      if (state_q == ST_HALT) state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (en) begin
            if (at_term) begin
              if (!mode) begin
                count_d = '0;
                wrap_d  = 1'b1;
`ifdef UPCNT_OVF_EN
                // A terminal wrap at all-ones is also a true rollover.
                if (all_ones) ovf_d = 1'b1;
`endif
              end else begin
                state_d = ST_HALT;
              end
            end else begin
              count_d = count_q + WIDTH'(1);
`ifdef UPCNT_OVF_EN
              if (all_ones) ovf_d = 1'b1;
`endif
            end
          end
        end
        ST_HALT: begin
          if (start) begin
            count_d = '0;
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef UPCNT_OVF_EN
  always_ff @(posedge clk) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign count = count_q;
  assign tc    = at_term;
  assign wrap  = wrap_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_HALT);

endmodule
